// File: rtl/frequency_analyzer_pkg.sv
// Shared definitions for the frequency dump sequencer: dump FSM states,
// header field placement and the words-per-dump count.
// Optional feature macro: FREQUENCY_DUMP_HEADER_EN (adds a header word).
package frequency_analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

    // Header word layout: {dump_seq[15:0], CHANNELS[15:0]}
    localparam int HDR_SEQ_LSB = 16;
    localparam int HDR_SEQ_W   = 16;
    localparam int HDR_CH_LSB  = 0;
    localparam int HDR_CH_W    = 16;

    // Number of stream words emitted per dump.
    function automatic int words_per_dump(input int channels);
`ifdef FREQUENCY_DUMP_HEADER_EN
        return 2 * channels + 1;
`else
        return 2 * channels;
`endif
    endfunction

endpackage

// File: rtl/frequency_snapshot_bank.sv
// Snapshot registers for the per-channel f1/f2 values plus the
// index-to-word read mux. Word k is f_values[k*VALUE_WIDTH +: VALUE_WIDTH].
module frequency_snapshot_bank #(
    parameter int CHANNELS    = 3,
    parameter int VALUE_WIDTH = 32,
    localparam int SW         = $clog2(2 * CHANNELS)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              i_capture,
    input  logic [2*CHANNELS*VALUE_WIDTH-1:0] i_values,
    input  logic [SW-1:0]                     i_sel,
    output logic [VALUE_WIDTH-1:0]            o_word
);
    localparam int NW = 2 * CHANNELS;

    logic [VALUE_WIDTH-1:0] r_snap [NW];

    // Capture all values at once; reset discards the snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NW; k++) r_snap[k] <= '0;
        end else if (i_capture) begin
            for (int k = 0; k < NW; k++) r_snap[k] <= i_values[k*VALUE_WIDTH +: VALUE_WIDTH];
        end
    end

    // Select the requested word; out-of-range indices read as zero.
    always_comb begin
        o_word = '0;
        if (32'(i_sel) < NW) o_word = r_snap[i_sel];
    end

endmodule

// File: rtl/frequency_dump_sequencer.sv
// Frequency analyzer control: run flag, analyzer clear pulse, and a
// snapshot dump streamed out over a valid/ready interface.
// Optional feature macro: FREQUENCY_DUMP_HEADER_EN (header word + dump_seq).
module frequency_dump_sequencer
    import frequency_analyzer_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int VALUE_WIDTH = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              clear_request,
    input  logic                              dump_request,
    input  logic [2*CHANNELS*VALUE_WIDTH-1:0] f_values,
    output logic                              analyzer_enable,
    output logic                              analyzer_clear_n,
    output logic [VALUE_WIDTH-1:0]            out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              irq,
    output logic                              busy,
    output logic                              dump_overrun
);
    localparam int WORDS = words_per_dump(CHANNELS);
    localparam int IW    = $clog2(WORDS + 1);
    localparam int SW    = $clog2(2 * CHANNELS);

    dump_state_t            r_state, w_next;
    logic [IW-1:0]          r_idx;
    logic                   r_run;
    logic                   r_clr_n;
    logic                   r_clr_pend;
    logic                   r_overrun;
    logic                   w_capture;
    logic                   w_final;
    logic [SW-1:0]          w_sel;
    logic [VALUE_WIDTH-1:0] w_val;
    logic [VALUE_WIDTH-1:0] w_word;

    assign w_capture = (r_state == ST_IDLE) && dump_request;
    assign w_final   = (r_idx == IW'(WORDS - 1));

    frequency_snapshot_bank #(
        .CHANNELS    (CHANNELS),
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_bank (
        .clock     (clock),
        .reset     (reset),
        .i_capture (w_capture),
        .i_values  (f_values),
        .i_sel     (w_sel),
        .o_word    (w_val)
    );

`ifdef FREQUENCY_DUMP_HEADER_EN
    logic [15:0] r_seq;
    logic [31:0] w_hdr;

    // Count completed dumps; wraps naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) r_seq <= '0;
        else if (r_state == ST_DONE) r_seq <= r_seq + 16'd1;
    end

    // Word 0 is the header, words 1.. map onto snapshot values 0..
    always_comb begin
        w_hdr = '0;
        w_hdr[HDR_SEQ_LSB +: HDR_SEQ_W] = r_seq;
        w_hdr[HDR_CH_LSB  +: HDR_CH_W]  = 16'(CHANNELS);
        w_sel  = SW'(r_idx - IW'(1));
        w_word = (r_idx == '0) ? VALUE_WIDTH'(w_hdr) : w_val;
    end
`else
    // Word index maps directly onto snapshot values.
    always_comb begin
        w_sel  = SW'(r_idx);
        w_word = w_val;
    end
`endif

    // Dump FSM state register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state and stream/status outputs.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        irq       = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: if (dump_request) w_next = ST_SEND;
            ST_SEND: begin
                out_valid = 1'b1;
                out_last  = w_final;
                out_data  = w_word;
                busy      = 1'b1;
                if (out_ready && w_final) w_next = ST_DONE;
            end
            ST_DONE: begin
                irq    = 1'b1;
                busy   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Word index: restart on capture, advance on each non-final transfer.
    always_ff @(posedge clock) begin
        if (reset)                                         r_idx <= '0;
        else if (w_capture)                                r_idx <= '0;
        else if (r_state == ST_SEND && out_ready && !w_final) r_idx <= r_idx + IW'(1);
    end

    // Run flag: stop has priority over start.
    always_ff @(posedge clock) begin
        if (reset)      r_run <= 1'b0;
        else if (stop)  r_run <= 1'b0;
        else if (start) r_run <= 1'b1;
    end

    // Sticky flag for dump requests dropped while a dump is in flight.
    always_ff @(posedge clock) begin
        if (reset)                     r_overrun <= 1'b0;
        else if (dump_request && busy) r_overrun <= 1'b1;
    end

    // Clear pulse: immediate when idle, deferred to the first idle cycle
    // after DONE when requested during a dump.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr_n    <= 1'b1;
            r_clr_pend <= 1'b0;
        end else begin
            r_clr_n <= 1'b1;
            case (r_state)
                ST_IDLE: if (clear_request) r_clr_n <= 1'b0;
                ST_SEND: if (clear_request) r_clr_pend <= 1'b1;
                ST_DONE: if (clear_request || r_clr_pend) begin
                    r_clr_n    <= 1'b0;
                    r_clr_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign analyzer_enable  = r_run;
    assign analyzer_clear_n = r_clr_n;
    assign dump_overrun     = r_overrun;

endmodule

// File: tb/tb_frequency_dump_sequencer.sv
// Scoreboard bench for frequency_dump_sequencer (CHANNELS=3, 32-bit values).
// Also builds with FREQUENCY_DUMP_HEADER_EN to exercise the header word.
module tb_frequency_dump_sequencer;
    logic         clock = 1'b0;
    logic         reset, start, stop, clear_request, dump_request, out_ready;
    logic [191:0] f_values;
    logic         analyzer_enable, analyzer_clear_n, out_valid, out_last;
    logic         irq, busy, dump_overrun;
    logic [31:0]  out_data;

    frequency_dump_sequencer #(.CHANNELS(3), .VALUE_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .clear_request(clear_request), .dump_request(dump_request),
        .f_values(f_values), .analyzer_enable(analyzer_enable),
        .analyzer_clear_n(analyzer_clear_n), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .irq(irq), .busy(busy), .dump_overrun(dump_overrun)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] q[$];            // {last, data}
    logic [31:0] vec [3][6];
    logic [15:0] exp_seq = 16'd0;
    int          clr_low = 0, clr_low_busy = 0, irq_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic set_f(input int s);
        for (int k = 0; k < 6; k++) f_values[k*32 +: 32] = vec[s][k];
    endtask

    task automatic push_exp(input int s);
`ifdef FREQUENCY_DUMP_HEADER_EN
        q.push_back({1'b0, exp_seq, 16'h0003});
`endif
        for (int k = 0; k < 6; k++) q.push_back({(k == 5), vec[s][k]});
    endtask

    task automatic pulse_dump;
        dump_request = 1'b1; tick; dump_request = 1'b0;
    endtask

    // Wait for the final word, then check the DONE cycle and the first idle cycle.
    task automatic wait_last(input bit exp_clr);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (out_valid && out_ready && out_last) found = 1'b1;
        end
        chk("last_seen", found, 1);
        if (found) begin
            @(negedge clock);
            chk("done_irq", irq, 1);
            chk("done_busy", busy, 1);
            chk("done_valid", out_valid, 0);
            @(negedge clock);
            chk("idle_irq", irq, 0);
            chk("idle_busy", busy, 0);
            chk("idle_clear_n", analyzer_clear_n, !exp_clr);
            exp_seq++;
        end
        chk("sb_empty", q.size(), 0);
    endtask

    // Monitor: pops expected words on every transfer, checks stall stability.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data  = '0;
        logic        prev_last  = 1'b0;
        logic [32:0] e;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (!analyzer_clear_n) begin
                    clr_low++;
                    if (busy) clr_low_busy++;
                end
                if (irq) irq_cnt++;
                if (out_valid && prev_stall) begin
                    chk("stall_data", out_data, prev_data);
                    chk("stall_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL extra_word: got %0h expected none", out_data);
                    end else begin
                        e = q.pop_front();
                        chk("word_data", out_data, e[31:0]);
                        chk("word_last", out_last, e[32]);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec[0] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005, 32'h6666_0006};
        vec[1] = '{32'hA0A0_0010, 32'hB1B1_0011, 32'hC2C2_0012, 32'hD3D3_0013, 32'hE4E4_0014, 32'hF5F5_0015};
        vec[2] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0001, 32'h7FFF_FFFE};
        reset = 1'b1; start = 0; stop = 0; clear_request = 0; dump_request = 0; out_ready = 1'b1;
        set_f(0);
        repeat (3) tick;
        @(negedge clock);
        chk("rst_enable", analyzer_enable, 0);
        chk("rst_clear_n", analyzer_clear_n, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", dump_overrun, 0);
        tick; reset = 1'b0;

        // start, then a full dump with out_ready held high
        start = 1'b1; tick; start = 1'b0;
        @(negedge clock);
        chk("start_enable", analyzer_enable, 1);
        push_exp(0);
        pulse_dump;
        set_f(1);                 // snapshot must not follow inputs
        @(negedge clock);
        chk("first_valid", out_valid, 1);
        wait_last(0);

        // out_ready toggling every cycle
        push_exp(1);
        pulse_dump;
        set_f(2);
        fork
            begin repeat (30) begin tick; out_ready = ~out_ready; end end
            wait_last(0);
        join
        out_ready = 1'b1;

        // stop alone, then start+stop together
        tick; stop = 1'b1; tick; stop = 1'b0;
        @(negedge clock);
        chk("stop_enable", analyzer_enable, 0);
        start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
        @(negedge clock);
        chk("startstop_enable", analyzer_enable, 0);

        // dump_request during SEND is dropped and flagged
        start = 1'b1; tick; start = 1'b0;
        push_exp(2);
        pulse_dump;
        set_f(0);
        fork
            wait_last(0);
            begin tick; dump_request = 1'b1; tick; dump_request = 0; end
        join
        chk("overrun_set", dump_overrun, 1);
        chk("run_independent", analyzer_enable, 1);
        repeat (3) @(negedge clock);
        chk("overrun_no_redump", out_valid, 0);

        // clear_request during SEND is deferred to first idle cycle
        clr_low = 0; clr_low_busy = 0;
        push_exp(0);
        pulse_dump;
        fork
            wait_last(1);
            begin tick; clear_request = 1'b1; tick; clear_request = 1'b0; end
        join
        @(negedge clock);
        chk("deferred_clr_count", clr_low, 1);
        chk("deferred_clr_busy", clr_low_busy, 0);
        chk("overrun_sticky", dump_overrun, 1);

        // simultaneous dump + clear in IDLE: snapshot taken, clear next cycle
        clr_low = 0;
        push_exp(0);
        dump_request = 1'b1; clear_request = 1'b1; tick;
        dump_request = 1'b0; clear_request = 1'b0;
        set_f(1);
        @(negedge clock);
        chk("idle_clr_low", analyzer_clear_n, 0);
        chk("idle_clr_valid", out_valid, 1);
        wait_last(0);
        chk("idle_clr_count", clr_low, 1);

        // reset in the middle of a dump
        push_exp(1);
        pulse_dump;
        tick; tick;
        reset = 1'b1;
        q.delete();
        tick;
        @(negedge clock);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_irq", irq, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_overrun", dump_overrun, 0);
        chk("midrst_enable", analyzer_enable, 0);
        tick; reset = 1'b0;
        exp_seq = 16'd0; irq_cnt = 0;
        repeat (10) @(negedge clock);
        chk("midrst_no_irq", irq_cnt, 0);
        chk("midrst_idle_valid", out_valid, 0);

        // fresh dump after reset (header sequence restarts)
        set_f(2);
        push_exp(2);
        tick;
        pulse_dump;
        wait_last(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
